servo_cmd_sequencer: RTL and testbench

Command-driven scheduler for the servo speed selector. Accepts (speed, duration) commands through a valid/ready handshake and queues them in a small FIFO. Drives the `sel` input of the existing `pulso` PWM generator for each command's duration, measured in slow ticks from an internal prescaler. Replaces hand-coded counter/sel sequencing in the motor test tops and returns the servo to stop when the queue is empty.

---
 rtl/servo_pkg.sv | 22 ++
 rtl/servo_cmd_sequencer_fifo.sv | 59 +++++
 rtl/servo_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_servo_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and types for the servo command sequencer.
package servo_pkg;

  // Command field widths matching the pulso speed select and tick counter.
  localparam int CMD_SEL_W = 3;
  localparam int CMD_DUR_W = 8;

  // Speed code that holds the servo still, and the highest legal code.
  localparam logic [2:0] STOP_SEL = 3'd0;
  localparam logic [2:0] MAX_SEL  = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CMD_SEL_W-1:0] sel;
    logic [CMD_DUR_W-1:0] dur;
  } cmd_t;

endpackage

// File: rtl/servo_cmd_sequencer_fifo.sv
// Command queue: synchronous FIFO with first-word fall-through read data
// and a synchronous flush.
module cmd_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Queues (speed, duration) commands and drives the pulso speed select for
// each command's duration in prescaler ticks; falls back to stop when idle.
module servo_cmd_sequencer #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int DUR_W      = 8,
  parameter int SEL_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic             tick_led
);

  import servo_pkg::*;

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int FW  = SEL_W + DUR_W;

  localparam logic [SEL_W-1:0] STOP = SEL_W'(STOP_SEL);
  localparam logic [SEL_W-1:0] MAXS = SEL_W'(MAX_SEL);

  logic [PW-1:0]    pcnt;
  logic             tick;
  state_t           state;
  logic [DUR_W-1:0] remaining;

  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    wdata;
  logic [FW-1:0]    rdata;
  logic [SEL_W-1:0] head_sel;
  logic [DUR_W-1:0] head_dur;
  logic             last_tick;

  assign tick      = (pcnt == PW'(DIV - 1));
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready && !abort;
  assign last_tick = (state == RUN) && tick && (remaining == DUR_W'(1));
  assign pop       = !abort && !fifo_empty && ((state == IDLE) || last_tick);

  // Sanitise at push time so the FSM never sees an illegal code or zero time.
  assign wdata = {(cmd_sel > MAXS) ? STOP : cmd_sel,
                  (cmd_dur == '0) ? DUR_W'(1) : cmd_dur};
  assign head_sel = rdata[FW-1:DUR_W];
  assign head_dur = rdata[DUR_W-1:0];

  cmd_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Free-running tick prescaler with heartbeat; commands never disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt     <= '0;
      tick_led <= 1'b0;
    end else if (tick) begin
      pcnt     <= '0;
      tick_led <= !tick_led;
    end else begin
      pcnt     <= pcnt + PW'(1);
    end
  end

  // Sequencer FSM: load from queue, count down ticks, chain or stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= STOP;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        sel       <= STOP;
        remaining <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              state     <= RUN;
              sel       <= head_sel;
              remaining <= head_dur;
              busy      <= 1'b1;
            end else begin
              sel  <= STOP;
              // A push into the empty queue keeps us busy from next cycle.
              busy <= push;
            end
          end
          RUN: begin
            busy <= 1'b1;
            if (tick) begin
              if (remaining == DUR_W'(1)) begin
                done <= 1'b1;
                if (!fifo_empty) begin
                  // Chain straight into the next command, no stop gap.
                  sel       <= head_sel;
                  remaining <= head_dur;
                end else begin
                  state     <= IDLE;
                  sel       <= STOP;
                  remaining <= '0;
                  busy      <= push;
                end
              end else begin
                remaining <= remaining - DUR_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            sel   <= STOP;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Bench for servo_cmd_sequencer: queue-level reference model compared on
// every cycle, plus directed scenarios with hand-derived timing windows.
module tb_servo_cmd_sequencer;
  import servo_pkg::*;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_sel = '0;
  logic [7:0] cmd_dur = '0;
  logic       abort = 1'b0;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic       tick_led;

  servo_cmd_sequencer #(
    .CLK_HZ     (100),
    .TICK_HZ    (10),
    .FIFO_DEPTH (DEPTH),
    .DUR_W      (8),
    .SEL_W      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_dur   (cmd_dur),
    .abort     (abort),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .tick_led  (tick_led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int last_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model (queue + current command) -------------
  cmd_t       q[$];
  cmd_t       cur;
  bit         active;
  int         left;
  int         pc;
  logic [2:0] m_sel;
  logic       m_busy, m_done, m_led;
  bit         m_tick, m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      active = 0; left = 0; pc = 0;
      m_sel = 0; m_busy = 0; m_done = 0; m_led = 0;
    end else begin
      m_tick = (pc == DIV - 1);
      pc = (pc + 1) % DIV;
      if (m_tick) m_led = !m_led;
      m_full = (q.size() == DEPTH);
      m_done = 0;
      if (abort) begin
        q.delete();
        active = 0; left = 0; m_sel = 0;
      end else begin
        if (!active) begin
          if (q.size() > 0) begin
            cur = q.pop_front();
            active = 1; m_sel = cur.sel; left = int'(cur.dur);
          end else m_sel = 0;
        end else if (m_tick) begin
          left = left - 1;
          if (left == 0) begin
            m_done = 1;
            if (q.size() > 0) begin
              cur = q.pop_front();
              m_sel = cur.sel; left = int'(cur.dur);
            end else begin
              active = 0; m_sel = 0;
            end
          end
        end
        if (cmd_valid && !m_full)
          q.push_back('{sel: (cmd_sel > 3'd4) ? 3'd0 : cmd_sel,
                        dur: (cmd_dur == 8'd0) ? 8'd1 : cmd_dur});
      end
      m_busy = active || (q.size() != 0);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sel", 32'(sel), 32'(m_sel));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("tick_led", 32'(tick_led), 32'(m_led));
      chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit         log_en = 0;
  logic [2:0] prev_sel;
  logic [2:0] seq[$];

  // Advance to 2 time units after the next falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
      if (log_en && sel !== prev_sel) begin
        seq.push_back(sel);
        prev_sel = sel;
      end
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [7:0] d);
    cmd_valid = 1; cmd_sel = s; cmd_dur = d;
    last_wait = 0;
    while (!cmd_ready && last_wait < 1000) begin
      step(1);
      last_wait++;
    end
    if (!cmd_ready) chk("push_timeout", 0, 1);
    step(1);
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string name, input int lo, input int hi);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    chk_rng(name, n, lo, hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, n;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1;
    // Reset state
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_led", 32'(tick_led), 0);
    chk("rst_ready", 32'(cmd_ready), 1);

    // 1. single command, 2-cycle latency, done within (20,30] cycles
    push(3'd2, 8'd3);
    chk("t1_sel_before", 32'(sel), 0);
    step(1);
    chk("t1_sel_latency", 32'(sel), 2);
    wait_done("t1_done_time", 21, 30);
    step(1);
    chk("t1_sel_end", 32'(sel), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // 2. back-to-back chain with no stop gap
    step(3);
    dc = done_cnt;
    prev_sel = sel; seq.delete(); log_en = 1;
    push(3'd1, 8'd2);
    push(3'd3, 8'd1);
    push(3'd4, 8'd2);
    step(80);
    log_en = 0;
    chk("t2_seq_len", 32'(seq.size()), 4);
    if (seq.size() == 4) begin
      chk("t2_seq0", 32'(seq[0]), 1);
      chk("t2_seq1", 32'(seq[1]), 3);
      chk("t2_seq2", 32'(seq[2]), 4);
      chk("t2_seq3", 32'(seq[3]), 0);
    end
    chk("t2_dones", 32'(done_cnt - dc), 3);

    // 3. backpressure
    push(3'd4, 8'd50);
    step(1);
    chk("t3_running", 32'(sel), 4);
    push(3'd1, 8'd5);
    push(3'd2, 8'd5);
    push(3'd3, 8'd5);
    push(3'd4, 8'd5);
    chk("t3_full", 32'(cmd_ready), 0);
    push(3'd1, 8'd1);
    chk_rng("t3_wait", last_wait, 470, 500);
    abort = 1; step(1); abort = 0;
    chk("t3_flushed", 32'(busy), 0);

    // 4. abort mid-run with two queued; push in abort cycle dropped
    push(3'd2, 8'd20);
    push(3'd3, 8'd5);
    push(3'd4, 8'd5);
    step(3);
    chk("t4_running", 32'(sel), 2);
    dc = done_cnt;
    abort = 1; cmd_valid = 1; cmd_sel = 3'd1; cmd_dur = 8'd3;
    step(1);
    abort = 0; cmd_valid = 0;
    chk("t4_sel", 32'(sel), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ready", 32'(cmd_ready), 1);
    step(40);
    chk("t4_no_done", 32'(done_cnt - dc), 0);
    chk("t4_still_idle", 32'(busy), 0);

    // 5. illegal sel and zero duration
    push(3'd7, 8'd2);
    step(1);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_sel_stop", 32'(sel), 0);
    wait_done("t5_done_time", 11, 20);
    step(1);
    chk("t5_idle", 32'(busy), 0);
    push(3'd1, 8'd0);
    step(1);
    chk("t5_sel1", 32'(sel), 1);
    n = 0;
    while (sel === 3'd1 && n < 50) begin
      step(1);
      n++;
    end
    chk_rng("t5_dur0_time", n, 1, 10);
    chk("t5_dur0_done", 32'(done), 1);

    // 6. async reset mid-run
    step(3);
    push(3'd3, 8'd30);
    push(3'd2, 8'd5);
    step(3);
    chk("t6_running", 32'(sel), 3);
    #1 rst_n = 0;
    #1;
    chk("t6_sel", 32'(sel), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_led", 32'(tick_led), 0);
    chk("t6_ready", 32'(cmd_ready), 1);
    step(2);
    rst_n = 1;
    dc = done_cnt;
    step(9);
    chk("t6_led_9", 32'(tick_led), 0);
    step(1);
    chk("t6_led_10", 32'(tick_led), 1);
    step(100);
    chk("t6_no_residual", 32'(done_cnt - dc), 0);
    chk("t6_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
